uart_frame_parser: RTL and testbench
====================================

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 Parameter DBITS, default 8: data word width; must match the Rx FIFO width.
REQ-002 Parameter MAX_LEN, default 16: maximum payload bytes per frame; power of two.
REQ-003 Parameter TIMEOUT, default 2000000: inter-byte timeout in clk_100MHz cycles (20 ms).
REQ-004 Parameter TO_BITS, default 21: timeout counter width; 2^TO_BITS > TIMEOUT.
REQ-005 clk_100MHz  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 rx_empty  in  1  Rx FIFO has no data.
REQ-008 read_data  in  DBITS  Rx FIFO head word, valid whenever rx_empty=0.
REQ-009 read_uart  out  1  one-cycle pop strobe to Rx FIFO.
REQ-010 out_data  out  DBITS  payload byte to consumer.
REQ-011 out_valid  out  1  out_data valid.
REQ-012 out_last  out  1  with out_valid, marks the final payload byte.
REQ-013 out_ready  in  1  consumer accepts out_data this cycle.
REQ-014 frame_ok  out  1  one-cycle pulse: frame passed the checksum.
REQ-015 frame_err  out  1  one-cycle pulse: frame rejected.
REQ-016 err_code  out  2  cause, held until next frame_err: 01 bad length, 10 checksum, 11 timeout.

Function
REQ-017 Frame format: SYNC=0xAA, LEN, LEN payload bytes, CHK; valid when (LEN + payload + CHK) mod 256 = 0.
REQ-018 read_uart is combinational: 1 exactly when rx_empty=0 and state is HUNT, LEN, PAYLOAD or CHK; at most one byte consumed per cycle.
REQ-019 A byte is consumed in the cycle read_uart=1; read_data is sampled in that same cycle.
REQ-020 States: HUNT, LEN, PAYLOAD, CHK, DRAIN.
REQ-021 HUNT: 0xAA -> LEN; any other byte is discarded silently.
REQ-022 LEN: value 1..MAX_LEN -> PAYLOAD, with the 8-bit running sum set to LEN.
REQ-023 LEN: value 0 or >MAX_LEN -> pulse frame_err, err_code=01, -> HUNT.
REQ-024 PAYLOAD: each byte is written to buffer index 0..LEN-1 and added to the sum mod 256; after byte LEN-1 -> CHK.
REQ-025 CHK: sum+byte = 0 mod 256 -> pulse frame_ok, -> DRAIN; otherwise pulse frame_err, err_code=10, -> HUNT, buffer discarded.
REQ-026 Timeout: counter clears on every consumed byte and counts only in LEN/PAYLOAD/CHK; at TIMEOUT-1 with no byte -> frame_err, err_code=11, -> HUNT.
REQ-027 A byte arriving in the same cycle the timeout expires is consumed and timeout is not flagged.
REQ-028 DRAIN: out_valid=1 and out_data=buffer[idx]; idx advances on out_valid&out_ready; out_last=1 when idx=LEN-1.
REQ-029 Accepting the last byte -> HUNT the next cycle; read_uart=0 throughout DRAIN (Rx FIFO backpressure; Rx FIFO overflow is upstream's concern).
REQ-030 out_data/out_valid/out_last are stable while out_valid=1 and out_ready=0.
REQ-031 frame_ok to first out_valid latency is 1 cycle; a held-high out_ready drains one byte per cycle.
REQ-032 0xAA inside PAYLOAD or CHK is treated as data, never as resync.

Reset
REQ-033 On reset: state=HUNT; idx, sum, timeout counter=0; read_uart, out_valid, out_last, frame_ok, frame_err=0; err_code=00; out_data=0.
REQ-034 Reset mid-frame or mid-drain discards all buffered payload with no frame_err pulse.
REQ-035 Buffer contents are not reset and are don't-care outside DRAIN.

Structure
REQ-036 Shared package uart_pkg holds the state encodings, err_code values and the SYNC_BYTE=0xAA constant.
REQ-037 One sub-module, frame_buffer: MAX_LEN x DBITS RAM with synchronous write and combinational read.
REQ-038 Target size is 150-300 lines of RTL; the block connects to uart_top's read_uart, rx_empty and read_data.

Verification
REQ-039 Stream AA 03 11 22 33 97 -> frame_ok once; out bytes 11,22,33 with out_last on 33; no frame_err.
REQ-040 Stream AA 02 10 20 00 -> frame_err with err_code=10; out_valid never asserted; next good frame is accepted.
REQ-041 Stream AA 00, then AA 11 (17 > MAX_LEN) -> two frame_err pulses with err_code=01; parser returns to HUNT.
REQ-042 Stream 55 AA 01 AA 55 -> 55 discarded; payload AA accepted; frame_ok; out_data=AA with out_last=1.
REQ-043 Stream AA 02 then stall TIMEOUT cycles -> frame_err with err_code=11 exactly TIMEOUT cycles after the last byte.
REQ-044 Send a good frame with out_ready toggling 1,0,0,1 while a second frame sits in the Rx FIFO -> data held stable; read_uart=0 until drain completes, then the second frame parses.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame parser: FSM state encodings, error causes and the sync byte.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_DRAIN
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CHK     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] SYNC_BYTE = 8'hAA;

endpackage

// File: rtl/frame_buffer.sv
// Payload store: MAX_LEN x DBITS RAM, synchronous write, combinational read.
// Zero-latency read; no flow control (the parser sequences writes and reads).
module frame_buffer #(
  parameter int DBITS   = 8,
  parameter int MAX_LEN = 16,
  parameter int AW      = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [DBITS-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [DBITS-1:0] rdata
);

  logic [DBITS-1:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Parses SYNC/LEN/payload/CHK frames from the Rx FIFO and replays good payloads as a valid/ready stream.
// First out_valid one cycle after frame_ok; the Rx FIFO is not popped while a payload is draining.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int DBITS   = 8,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 2000000,
  parameter int TO_BITS = 21
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             rx_empty,
  input  logic [DBITS-1:0] read_data,
  output logic             read_uart,
  output logic [DBITS-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [1:0]       err_code
);

  localparam int                 AW        = $clog2(MAX_LEN);
  localparam logic [DBITS-1:0]   MAX_LEN_W = DBITS'(MAX_LEN);
  localparam logic [TO_BITS-1:0] TO_LAST   = TO_BITS'(TIMEOUT - 1);

  state_t             state;
  logic [AW-1:0]      wr_idx;
  logic [AW-1:0]      last_idx;
  logic [AW-1:0]      idx;
  logic [AW-1:0]      rd_addr;
  logic [DBITS-1:0]   rd_data;
  logic [7:0]         sum;
  logic [7:0]         chk_sum;
  logic [TO_BITS-1:0] to_cnt;
  logic               in_frame;
  logic               timeout;

  assign in_frame  = state inside {ST_LEN, ST_PAYLOAD, ST_CHK};
  assign read_uart = !reset && !rx_empty && (in_frame || state == ST_HUNT);
  assign chk_sum   = sum + read_data[7:0];
  // A byte consumed in the expiry cycle wins over the timeout.
  assign timeout   = in_frame && !read_uart && (to_cnt == TO_LAST);
  // Look one entry ahead once a byte is presented so an accept can reload without a bubble.
  assign rd_addr   = out_valid ? idx + AW'(1) : idx;

  frame_buffer #(
    .DBITS  (DBITS),
    .MAX_LEN(MAX_LEN),
    .AW     (AW)
  ) u_buf (
    .clk  (clk_100MHz),
    .we   (read_uart && state == ST_PAYLOAD),
    .waddr(wr_idx),
    .wdata(read_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state     <= ST_HUNT;
      wr_idx    <= '0;
      last_idx  <= '0;
      idx       <= '0;
      sum       <= '0;
      to_cnt    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      to_cnt    <= (read_uart || !in_frame) ? '0 : to_cnt + TO_BITS'(1);

      if (timeout) begin
        frame_err <= 1'b1;
        err_code  <= ERR_TIMEOUT;
        state     <= ST_HUNT;
      end else begin
        case (state)
          ST_HUNT: begin
            if (read_uart && read_data == DBITS'(SYNC_BYTE)) state <= ST_LEN;
          end
          ST_LEN: begin
            if (read_uart) begin
              if (read_data != '0 && read_data <= MAX_LEN_W) begin
                sum      <= read_data[7:0];
                last_idx <= AW'(read_data - DBITS'(1));
                wr_idx   <= '0;
                state    <= ST_PAYLOAD;
              end else begin
                frame_err <= 1'b1;
                err_code  <= ERR_LEN;
                state     <= ST_HUNT;
              end
            end
          end
          ST_PAYLOAD: begin
            if (read_uart) begin
              sum <= chk_sum;
              if (wr_idx == last_idx) state <= ST_CHK;
              else wr_idx <= wr_idx + AW'(1);
            end
          end
          ST_CHK: begin
            if (read_uart) begin
              if (chk_sum == 8'h00) begin
                frame_ok <= 1'b1;
                idx      <= '0;
                state    <= ST_DRAIN;
              end else begin
                frame_err <= 1'b1;
                err_code  <= ERR_CHK;
                state     <= ST_HUNT;
              end
            end
          end
          ST_DRAIN: begin
            if (!out_valid) begin
              out_valid <= 1'b1;
              out_data  <= rd_data;
              out_last  <= (rd_addr == last_idx);
            end else if (out_ready) begin
              if (out_last) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                state     <= ST_HUNT;
              end else begin
                idx      <= rd_addr;
                out_data <= rd_data;
                out_last <= (rd_addr == last_idx);
              end
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: Rx FIFO model, table-driven frames and a result scoreboard.
module tb_uart_frame_parser;

  localparam int TIMEOUT = 40;

  logic       clk_100MHz;
  logic       reset;
  logic       rx_empty;
  logic [7:0] read_data;
  logic       read_uart;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  uart_frame_parser #(
    .DBITS(8), .MAX_LEN(16), .TIMEOUT(TIMEOUT), .TO_BITS(6)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .reset     (reset),
    .rx_empty  (rx_empty),
    .read_data (read_data),
    .read_uart (read_uart),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct {
    int          n;     // stream bytes, MSB first in s
    logic [63:0] s;
    bit          ok;
    logic [1:0]  code;
    int          nev;   // number of identical verdict events
    int          plen;  // expected payload bytes, MSB first in p
    logic [31:0] p;
  } vec_t;

  vec_t       vecs[7];
  int         checks, errors;
  logic [7:0] rx_q[$];
  logic [8:0] exp_b[$];   // {last, data}
  logic [2:0] exp_e[$];   // 3'b100 frame_ok, else {0, err_code}
  int         cyc, last_pop_cyc, rdy_mode, pat_i;
  logic [3:0] pat;
  logic       pop_pending;
  logic       p_ok, p_vld, p_rdy, p_last;
  logic [7:0] p_dat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic refresh();
    rx_empty  = (rx_q.size() == 0);
    read_data = rx_empty ? 8'h00 : rx_q[0];
  endtask

  task automatic push(input logic [7:0] b);
    rx_q.push_back(b);
    refresh();
  endtask

  task automatic monitor();
    logic [2:0] obs, ev;
    logic [8:0] eb;
    if (reset) begin
      p_ok = 0; p_vld = 0; p_rdy = 0; p_last = 0; p_dat = 0;
      return;
    end
    if (p_ok) chk("ok_to_valid", out_valid, 1);
    if (p_vld && !p_rdy) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, p_dat);
      chk("hold_last", out_last, p_last);
    end else if (p_vld && p_rdy && !p_last) chk("stream_valid", out_valid, 1);
    else if (p_vld && p_rdy && p_last) chk("after_last_valid", out_valid, 0);
    if (out_valid || frame_ok) chk("no_read_in_drain", read_uart, 0);
    if (read_uart) chk("read_needs_data", rx_empty, 0);
    if (out_valid && out_ready) begin
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_byte: got %0h required none", out_data);
      end else begin
        eb = exp_b.pop_front();
        chk("out_data", out_data, eb[7:0]);
        chk("out_last", out_last, eb[8]);
      end
    end
    if (frame_ok || frame_err) begin
      obs = frame_ok ? 3'b100 : {1'b0, err_code};
      if (exp_e.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_event: got %0h required none", obs);
      end else begin
        ev = exp_e.pop_front();
        chk("event", obs, ev);
        if (frame_err && err_code == 2'b11) chk("timeout_latency", cyc - last_pop_cyc, TIMEOUT);
      end
    end
    p_ok = frame_ok; p_vld = out_valid; p_rdy = out_ready; p_last = out_last; p_dat = out_data;
  endtask

  task automatic tick();
    @(negedge clk_100MHz);
    monitor();
    pop_pending = read_uart;
    @(posedge clk_100MHz);
    cyc++;
    #1;
    if (pop_pending && rx_q.size() != 0) begin
      void'(rx_q.pop_front());
      last_pop_cyc = cyc;
    end
    refresh();
    pat_i++;
    out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? pat[pat_i % 4] : 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while ((rx_q.size() != 0 || exp_b.size() != 0 || exp_e.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (rx_q.size() != 0 || exp_b.size() != 0 || exp_e.size() != 0) begin
      errors++;
      $display("FAIL drain_budget: pending rx=%0d bytes=%0d events=%0d required 0/0/0",
               rx_q.size(), exp_b.size(), exp_e.size());
    end
    repeat (3) tick();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; last_pop_cyc = 0; pat_i = 0; rdy_mode = 0;
    pat = 4'b1001;
    p_ok = 0; p_vld = 0; p_rdy = 0; p_last = 0; p_dat = 0;
    reset = 1; out_ready = 1;
    refresh();

    vecs[0] = '{6, 64'hAA0311223397, 1'b1, 2'b00, 1, 3, 32'h112233};
    vecs[1] = '{5, 64'hAA02102000,   1'b0, 2'b10, 1, 0, 32'h0};
    vecs[2] = '{5, 64'hAA021020CE,   1'b1, 2'b00, 1, 2, 32'h1020};
    vecs[3] = '{4, 64'hAA00AA11,     1'b0, 2'b01, 2, 0, 32'h0};
    vecs[4] = '{5, 64'h55AA01AA55,   1'b1, 2'b00, 1, 1, 32'hAA};
    vecs[5] = '{4, 64'hAA0100FF,     1'b1, 2'b00, 1, 1, 32'h00};
    vecs[6] = '{4, 64'hAA0105FB,     1'b0, 2'b10, 1, 0, 32'h0};

    // Reset state, with a byte waiting that must not be popped
    push(8'h55);
    tick(); tick();
    chk("rst_read_uart", read_uart, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_frame_ok", frame_ok, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_err_code", err_code, 0);
    reset = 0;

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < vecs[v].n; i++) push(vecs[v].s[8*(vecs[v].n-1-i) +: 8]);
      for (int k = 0; k < vecs[v].nev; k++)
        exp_e.push_back(vecs[v].ok ? 3'b100 : {1'b0, vecs[v].code});
      for (int i = 0; i < vecs[v].plen; i++)
        exp_b.push_back({(i == vecs[v].plen - 1), vecs[v].p[8*(vecs[v].plen-1-i) +: 8]});
      run_until_done(200);
    end

    // Longest legal frame: LEN=16, payload 0..15, checksum 0x78
    exp_e.push_back(3'b100);
    push(8'hAA); push(8'h10);
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      exp_b.push_back({(i == 15), 8'(i)});
    end
    push(8'h78);
    run_until_done(200);

    // Stall after LEN: timeout error exactly TIMEOUT cycles after the last byte
    exp_e.push_back(3'b011);
    push(8'hAA); push(8'h02);
    run_until_done(TIMEOUT + 30);

    // Byte arriving in the expiry cycle is taken; no timeout
    exp_e.push_back(3'b100);
    exp_b.push_back({1'b0, 8'h01});
    exp_b.push_back({1'b1, 8'h02});
    push(8'hAA); push(8'h02);
    for (int n = 0; n < 20 && rx_q.size() != 0; n++) tick();
    repeat (TIMEOUT - 1) tick();
    push(8'h01); push(8'h02); push(8'hFB);
    run_until_done(100);

    // Toggling out_ready with a second frame queued behind the first
    rdy_mode = 1;
    exp_e.push_back(3'b100); exp_e.push_back(3'b100);
    exp_b.push_back({1'b0, 8'h11}); exp_b.push_back({1'b0, 8'h22});
    exp_b.push_back({1'b1, 8'h33}); exp_b.push_back({1'b1, 8'hAA});
    push(8'hAA); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h97);
    push(8'hAA); push(8'h01); push(8'hAA); push(8'h55);
    run_until_done(300);
    rdy_mode = 0;

    // Reset mid-frame: silent discard, then a clean frame
    push(8'hAA); push(8'h04); push(8'h01); push(8'h02);
    for (int n = 0; n < 20 && rx_q.size() != 0; n++) tick();
    reset = 1; tick(); tick(); reset = 0;
    exp_e.push_back(3'b100);
    exp_b.push_back({1'b1, 8'h00});
    push(8'hAA); push(8'h01); push(8'h00); push(8'hFF);
    run_until_done(100);

    // Reset mid-drain: payload dropped, output idle, next frame fine
    rdy_mode = 2; out_ready = 0;
    exp_e.push_back(3'b100);
    push(8'hAA); push(8'h02); push(8'h10); push(8'h20); push(8'hCE);
    for (int n = 0; n < 50 && !out_valid; n++) tick();
    chk("drain_reached", out_valid, 1);
    reset = 1; tick(); tick(); reset = 0;
    chk("rst_drain_valid", out_valid, 0);
    exp_b.delete();
    rdy_mode = 0; out_ready = 1;
    exp_e.push_back(3'b100);
    exp_b.push_back({1'b1, 8'hAA});
    push(8'hAA); push(8'h01); push(8'hAA); push(8'h55);
    run_until_done(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
